instr_cache: RTL and testbench



---
 rtl/icache_pkg.sv | 15 +
 rtl/icache_word_sel.sv | 10 +
 rtl/instr_cache.sv | 77 +++++++
 tb/tb_instr_cache.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM encoding and address field positions for the cache blocks
package icache_pkg;
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;
  localparam int TAG_MSB = 9;
  localparam int TAG_LSB = 7;
  localparam int IDX_MSB = 6;
  localparam int IDX_LSB = 4;
  localparam int OFF_MSB = 3;
  localparam int OFF_LSB = 2;
  localparam int BLOCK_W = 128;
endpackage

// File: rtl/icache_word_sel.sv
// icache_word_sel: pick one 32-bit word out of a cache block by word offset
module icache_word_sel #(
  parameter int WORDS = 4
) (
  input  logic [32*WORDS-1:0]       block,
  input  logic [$clog2(WORDS)-1:0]  off,
  output logic [31:0]               word
);
  assign word = block[32*off +: 32];
endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped read-only instruction cache; ICACHE_PERF_CNT_EN adds hit/miss counters
module instr_cache
  import icache_pkg::*;
#(
  parameter int ADDR_W          = 10,
  parameter int NUM_SETS        = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic [ADDR_W-1:0]  ADDRESS,
  output logic [31:0]        INSTRUCTION,
  output logic               BUSYWAIT,
  output logic               MEM_READ,
  output logic [5:0]         MEM_ADDRESS,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [15:0]        HIT_COUNT,
  output logic [15:0]        MISS_COUNT
`endif
);
  state_t state, next;
  logic [TAG_MSB-TAG_LSB:0] tag;
  logic [IDX_MSB-IDX_LSB:0] idx;
  logic [OFF_MSB-OFF_LSB:0] off;
  logic [NUM_SETS-1:0] valid;
  logic [TAG_MSB-TAG_LSB:0] tag_mem [NUM_SETS];
  logic [BLOCK_W-1:0] data_mem [NUM_SETS];
  logic hit;
  logic unused_ok;
  assign tag = ADDRESS[TAG_MSB:TAG_LSB];
  assign idx = ADDRESS[IDX_MSB:IDX_LSB];
  assign off = ADDRESS[OFF_MSB:OFF_LSB];
  assign unused_ok = ^ADDRESS[1:0];
  assign hit = READ & valid[idx] & (tag_mem[idx] == tag);
  assign MEM_ADDRESS = {tag, idx};
  icache_word_sel #(.WORDS(WORDS_PER_BLOCK)) u_word_sel (
    .block(data_mem[idx]),
    .off  (off),
    .word (INSTRUCTION)
  );
  // state register; reset abandons any fill in flight
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= S_IDLE;
    else state <= next;
  // next state and handshake outputs; BUSYWAIT is forced low while reset is held
  always_comb begin
    next = state == S_IDLE     ? (READ & ~hit ? S_MEM_READ : S_IDLE) :
           state == S_MEM_READ ? (MEM_BUSYWAIT ? S_MEM_READ : S_UPDATE) : S_IDLE;
    MEM_READ = state == S_MEM_READ;
    BUSYWAIT = ~RESET & ((READ & ~hit) | (state != S_IDLE));
  end
  // valid bits are the only storage cleared by reset
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) valid <= '0;
    else if (state == S_UPDATE) valid[idx] <= 1'b1;
  // line fill; address is held stable by the CPU for the whole miss
  always_ff @(posedge CLK)
    if (state == S_UPDATE) begin
      data_mem[idx] <= MEM_READDATA;
      tag_mem[idx]  <= tag;
    end
`ifdef ICACHE_PERF_CNT_EN
  // saturating counters: served fetches and miss starts
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      if (state == S_IDLE && hit && HIT_COUNT != '1) HIT_COUNT <= HIT_COUNT + 16'd1;
      if (state == S_IDLE && next == S_MEM_READ && MISS_COUNT != '1) MISS_COUNT <= MISS_COUNT + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed plus random fetches against a tag/valid reference model
module tb_instr_cache;
  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         READ = 1'b0;
  logic [9:0]   ADDRESS = '0;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_PERF_CNT_EN
  logic [15:0]  HIT_COUNT, MISS_COUNT;
`endif
  int compared = 0;
  int mismatched = 0;
  int lat = 1;
  int cnt = 0;
  int hits_exp = 0;
  int misses_exp = 0;
  logic [31:0] imem [256];
  bit          mval [8];
  logic [2:0]  mtag [8];

  instr_cache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .ADDRESS(ADDRESS),
    .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef ICACHE_PERF_CNT_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // memory: the request stays in MEM_READ for exactly lat cycles
  always @(posedge CLK) cnt <= MEM_READ ? cnt + 1 : 0;
  assign MEM_BUSYWAIT = MEM_READ && (cnt < lat - 1);
  assign MEM_READDATA = {imem[{MEM_ADDRESS, 2'd3}], imem[{MEM_ADDRESS, 2'd2}],
                         imem[{MEM_ADDRESS, 2'd1}], imem[{MEM_ADDRESS, 2'd0}]};

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mval[i] = 1'b0;
  endtask

  task automatic fetch(input logic [9:0] a, input int l);
    bit exp_hit;
    int busy, mr, idx;
    idx = int'(a[6:4]);
    @(posedge CLK); #1;
    READ = 1'b1; ADDRESS = a; lat = l;
    @(negedge CLK);
    exp_hit = mval[idx] && mtag[idx] == a[9:7];
    busy = 0; mr = 0;
    while (BUSYWAIT && busy < 200) begin
      busy++;
      if (MEM_READ) begin
        mr++;
        if (mr == 1) chk("mem_address", 32'(MEM_ADDRESS), 32'(a[9:4]));
      end
      @(negedge CLK);
    end
    chk("busy_cycles", 32'(busy), exp_hit ? 32'd0 : 32'(l + 2));
    chk("mem_read_cycles", 32'(mr), exp_hit ? 32'd0 : 32'(l));
    chk("instruction", INSTRUCTION, imem[a[9:2]]);
    if (!exp_hit) begin
      mval[idx] = 1'b1;
      mtag[idx] = a[9:7];
      misses_exp++;
    end
    hits_exp++;
    @(posedge CLK); #1;
    READ = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    for (int i = 0; i < 4; i++) imem[i] = 32'(i + 1);
    clear_model();
    #2;
    chk("reset_mem_read", 32'(MEM_READ), 32'd0);
    chk("reset_busywait", 32'(BUSYWAIT), 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    // cold miss on 0x000 with five memory cycles, then sequential hits
    fetch(10'h000, 5);
    chk("first_word", INSTRUCTION, 32'h00000001);
    fetch(10'h004, 3);
    chk("second_word", INSTRUCTION, 32'h00000002);
    fetch(10'h008, 3);
    fetch(10'h00C, 3);
    chk("fourth_word", INSTRUCTION, 32'h00000004);
`ifdef ICACHE_PERF_CNT_EN
    chk("miss_count_plan", 32'(MISS_COUNT), 32'd1);
    chk("hit_count_plan", 32'(HIT_COUNT), 32'd4);
`endif
    // conflict thrash between 0x000 and 0x080
    fetch(10'h000, 2);
    fetch(10'h080, 3);
    fetch(10'h000, 2);
    fetch(10'h080, 1);
    // reset mid-fill of 0x040
    @(posedge CLK); #1;
    READ = 1'b1; ADDRESS = 10'h040; lat = 5;
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_fill_mem_read", 32'(MEM_READ), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("async_mem_read_drop", 32'(MEM_READ), 32'd0);
    chk("async_busywait_drop", 32'(BUSYWAIT), 32'd0);
    READ = 1'b0;
    clear_model();
    hits_exp = 0;
    misses_exp = 0;
    @(negedge CLK);
    RESET = 1'b0;
    fetch(10'h000, 4);
    // idle cycles with READ low
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      READ = 1'b0; ADDRESS = 10'($urandom);
      @(negedge CLK);
      chk("idle_busywait", 32'(BUSYWAIT), 32'd0);
      chk("idle_mem_read", 32'(MEM_READ), 32'd0);
    end
    fetch(10'h008, 3);
    // random fetch mix over a few lines and two tags
    for (int i = 0; i < 40; i++) begin
      fetch(10'(($urandom_range(0, 1) << 7) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2)),
            int'($urandom_range(1, 6)));
    end
`ifdef ICACHE_PERF_CNT_EN
    chk("miss_count_final", 32'(MISS_COUNT), 32'(misses_exp));
    chk("hit_count_final", 32'(HIT_COUNT), 32'(hits_exp));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
